// File: rtl/pfd_lock_detect.sv
// +----------------------------------------------------------------------------+
// | pfd_lock_detect                                                            |
// | PLL lock detector: measures per-reference-period PFD phase error on an     |
// | oversampling clock and qualifies lock with hysteresis.                     |
// | Optional sticky loss-of-lock flag: define PFD_LOCK_DETECT_STICKY_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pfd_lock_detect #(
    parameter int ERR_W      = 8,
    parameter int TOL        = 4,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refclk,
    input  logic             up,
    input  logic             down,
`ifdef PFD_LOCK_DETECT_STICKY_EN
    input  logic             lol_clr,
    output logic             lol_sticky,
`endif
    output logic             locked,
    output logic [1:0]       state,
    output logic [ERR_W-1:0] phase_err,
    output logic             ref_missing
);

    localparam int PER_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [PER_W-1:0] c_PER_LAST   = PER_W'(TIMEOUT - 1);
    localparam logic [RUN_W-1:0] c_LOCK_CNT   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] c_UNLOCK_CNT = RUN_W'(UNLOCK_CNT);

    localparam logic [1:0] c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0] c_ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED   = 2'd2;
    localparam logic [1:0] c_ST_SLIP     = 2'd3;

    logic             r_ref_meta, r_ref_s, r_ref_d;
    logic             r_up_meta, r_up_s;
    logic             r_dn_meta, r_dn_s;
    logic [ERR_W-1:0] r_err_cnt;
    logic [PER_W-1:0] r_per_cnt;
    logic             r_window_valid;
    logic [RUN_W-1:0] r_run_cnt;
    logic [1:0]       r_state;
    logic             r_locked;
    logic [ERR_W-1:0] r_phase_err;
    logic             r_ref_missing;

    logic             w_ref_rise;
    logic             w_diff;
    logic             w_timeout;
    logic             w_eval;
    logic             w_good;
    logic             w_bad;
    logic [RUN_W-1:0] w_run_inc;
    logic [1:0]       w_state_nxt;
    logic [RUN_W-1:0] w_run_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_meta <= 1'b0;
            r_ref_s    <= 1'b0;
            r_ref_d    <= 1'b0;
            r_up_meta  <= 1'b0;
            r_up_s     <= 1'b0;
            r_dn_meta  <= 1'b0;
            r_dn_s     <= 1'b0;
        end else begin
            r_ref_meta <= refclk;
            r_ref_s    <= r_ref_meta;
            r_ref_d    <= r_ref_s;
            r_up_meta  <= up;
            r_up_s     <= r_up_meta;
            r_dn_meta  <= down;
            r_dn_s     <= r_dn_meta;
        end
    end

    assign w_ref_rise = r_ref_s & ~r_ref_d;
    assign w_diff     = r_up_s ^ r_dn_s;
    // A reference edge landing on the last timeout cycle suppresses the timeout.
    assign w_timeout  = (r_per_cnt == c_PER_LAST) & ~w_ref_rise;
    assign w_eval     = w_ref_rise & r_window_valid;
    assign w_good     = w_eval & (int'(r_err_cnt) <= TOL);
    assign w_bad      = (w_eval & (int'(r_err_cnt) > TOL)) | w_timeout;
    assign w_run_inc  = r_run_cnt + RUN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt      <= '0;
            r_per_cnt      <= '0;
            r_window_valid <= 1'b0;
            r_phase_err    <= '0;
            r_ref_missing  <= 1'b0;
        end else if (w_ref_rise) begin
            r_err_cnt      <= ERR_W'(w_diff);
            r_per_cnt      <= '0;
            r_window_valid <= 1'b1;
            r_ref_missing  <= 1'b0;
            if (r_window_valid) begin
                r_phase_err <= r_err_cnt;
            end
        end else if (w_timeout) begin
            r_err_cnt      <= '0;
            r_per_cnt      <= '0;
            r_window_valid <= 1'b0;
            r_ref_missing  <= 1'b1;
        end else begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
            if (w_diff && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    // run_cnt is zero on entry to UNLOCKED/LOCKED, so the first event of a
    // run shares the increment-and-compare path; this covers counts of 1.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_cnt;
        case (r_state)
            c_ST_UNLOCKED, c_ST_ACQUIRE: begin
                if (w_good) begin
                    if (w_run_inc == c_LOCK_CNT) begin
                        w_state_nxt = c_ST_LOCKED;
                        w_run_nxt   = '0;
                    end else begin
                        w_state_nxt = c_ST_ACQUIRE;
                        w_run_nxt   = w_run_inc;
                    end
                end else if (w_bad) begin
                    w_state_nxt = c_ST_UNLOCKED;
                    w_run_nxt   = '0;
                end
            end
            default: begin
                if (w_bad) begin
                    if (w_run_inc == c_UNLOCK_CNT) begin
                        w_state_nxt = c_ST_UNLOCKED;
                        w_run_nxt   = '0;
                    end else begin
                        w_state_nxt = c_ST_SLIP;
                        w_run_nxt   = w_run_inc;
                    end
                end else if (w_good) begin
                    w_state_nxt = c_ST_LOCKED;
                    w_run_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_UNLOCKED;
            r_run_cnt <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_nxt;
            r_locked  <= (w_state_nxt == c_ST_LOCKED) || (w_state_nxt == c_ST_SLIP);
        end
    end

`ifdef PFD_LOCK_DETECT_STICKY_EN
    logic w_lol_set;
    logic r_lol_sticky;

    assign w_lol_set = (r_state == c_ST_SLIP) && (w_state_nxt == c_ST_UNLOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lol_sticky <= 1'b0;
        end else if (w_lol_set) begin
            r_lol_sticky <= 1'b1;
        end else if (lol_clr) begin
            r_lol_sticky <= 1'b0;
        end
    end

    assign lol_sticky = r_lol_sticky;
`endif

    assign locked      = r_locked;
    assign state       = r_state;
    assign phase_err   = r_phase_err;
    assign ref_missing = r_ref_missing;

endmodule

`default_nettype wire
